timestamp_scheduler: RTL and testbench

- Controller for the two-bank (ping-pong) 16-bit timestamp memory.
- Loader side: takes a timestamp table from a valid/ready stream and writes it into the shadow bank.
- Playback side: reads the active bank in address order and pulses trig_o when a free-running frame counter reaches each stored timestamp.
- Bank swap happens only at a frame boundary, so a new table replaces the old one glitch-free.

---
 rtl/timing_pkg.sv | 20 ++
 rtl/ts_loader.sv | 56 +++++
 rtl/timestamp_scheduler.sv | 157 +++++++++++++++
 tb/tb_timestamp_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared types and constants for the timestamp scheduler.
// Optional feature macro: TS_TICK_EN (adds tick_i; frame counter advances only on ticks).
package timing_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 16;

  // Bank-select encoding shared by writer and reader
  localparam logic SEL_WR0_RD1 = 1'b0;
  localparam logic SEL_WR1_RD0 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWAP,
    ST_FETCH,
    ST_WAIT,
    ST_END
  } state_e;

endpackage

// File: rtl/ts_loader.sv
// Stream loader: writes an incoming timestamp table into the shadow bank.
module ts_loader
  import timing_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  input  logic              consume_i,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wen_o,
  output logic              shadow_ready_o,
  output logic [ADDR_W:0]   shadow_len_o
);

  localparam logic [ADDR_W-1:0] WADDR_MAX = '1;

  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W:0]   shadow_len_q;
  logic              shadow_ready_q;
  logic              accept_c;

  assign accept_c       = s_valid_i & ~shadow_ready_q;
  assign s_ready_o      = ~shadow_ready_q;
  assign mem_wen_o      = accept_c;
  assign mem_waddr_o    = waddr_q;
  assign mem_wdata_o    = accept_c ? s_data_i : '0;
  assign shadow_ready_o = shadow_ready_q;
  assign shadow_len_o   = shadow_len_q;

  // Write pointer, table length and shadow-full flag
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      waddr_q        <= '0;
      shadow_len_q   <= '0;
      shadow_ready_q <= 1'b0;
    end else if (accept_c) begin
      if (s_last_i || (waddr_q == WADDR_MAX)) begin
        shadow_len_q   <= {1'b0, waddr_q} + (ADDR_W+1)'(1);
        shadow_ready_q <= 1'b1;
        waddr_q        <= '0;
      end else begin
        waddr_q <= waddr_q + ADDR_W'(1);
      end
    end else if (consume_i) begin
      shadow_ready_q <= 1'b0;
    end
  end

endmodule

// File: rtl/timestamp_scheduler.sv
// Ping-pong timestamp memory controller: loads tables into the shadow bank and
// plays the active bank back against a free-running frame counter.
// Optional feature macro: TS_TICK_EN (adds tick_i; counter advances only on ticks).
module timestamp_scheduler
  import timing_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
`ifdef TS_TICK_EN
  input  logic              tick_i,
`endif
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wen_o,
  output logic              mem_sel_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_ts_i,
  output logic              trig_o,
  output logic              frame_o,
  output logic              busy_o,
  output logic              shadow_ready_o,
  output logic              err_o
);

  state_e            state_q;
  logic              sel_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [DATA_W-1:0] cnt_q;
  logic [ADDR_W:0]   active_len_q;
  logic              stop_q;
  logic              frame_q;
  logic              err_q;

  logic              shadow_ready_c;
  logic [ADDR_W:0]   shadow_len_c;
  logic              consume_c;
  logic              adv_c;
  logic [DATA_W-1:0] cnt_inc_c;
  logic              hit_c;
  logic              last_c;

  ts_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .s_data_i       (s_data_i),
    .s_valid_i      (s_valid_i),
    .s_last_i       (s_last_i),
    .s_ready_o      (s_ready_o),
    .consume_i      (consume_c),
    .mem_waddr_o    (mem_waddr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wen_o      (mem_wen_o),
    .shadow_ready_o (shadow_ready_c),
    .shadow_len_o   (shadow_len_c)
  );

`ifdef TS_TICK_EN
  assign adv_c = tick_i;
`else
  assign adv_c = 1'b1;
`endif

  assign consume_c   = (state_q == ST_SWAP);
  assign cnt_inc_c   = adv_c ? (cnt_q + DATA_W'(1)) : cnt_q;
  // ">=" lets a late or duplicate timestamp fire at once instead of waiting a wrap
  assign hit_c       = (cnt_q >= mem_ts_i);
  assign last_c      = ({1'b0, raddr_q} == (active_len_q - (ADDR_W+1)'(1)));

  assign trig_o         = (state_q == ST_WAIT) && hit_c;
  assign busy_o         = (state_q != ST_IDLE);
  assign frame_o        = frame_q;
  assign err_o          = err_q;
  assign mem_sel_o      = sel_q;
  assign mem_raddr_o    = raddr_q;
  assign shadow_ready_o = shadow_ready_c;

  // Playback FSM with frame counter, bank select and stop request
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      sel_q        <= SEL_WR0_RD1;
      raddr_q      <= '0;
      cnt_q        <= '0;
      active_len_q <= '0;
      stop_q       <= 1'b0;
      frame_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      if (stop_i && (state_q != ST_IDLE)) begin
        stop_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (shadow_ready_c) begin
              state_q <= ST_SWAP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SWAP: begin
          sel_q        <= (sel_q == SEL_WR1_RD0) ? SEL_WR0_RD1 : SEL_WR1_RD0;
          active_len_q <= shadow_len_c;
          raddr_q      <= '0;
          cnt_q        <= '0;
          frame_q      <= 1'b1;
          state_q      <= ST_FETCH;
        end
        ST_FETCH: begin
          cnt_q   <= cnt_inc_c;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_inc_c;
          if (hit_c) begin
            if (last_c) begin
              state_q <= ST_END;
            end else begin
              raddr_q <= raddr_q + ADDR_W'(1);
              state_q <= ST_FETCH;
            end
          end
        end
        ST_END: begin
          if (stop_q) begin
            stop_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (shadow_ready_c) begin
            state_q <= ST_SWAP;
          end else begin
            raddr_q <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timestamp_scheduler.sv
// Scoreboard bench for timestamp_scheduler with a two-bank memory model.
module tb_timestamp_scheduler;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] EV_TRIG  = 2'd0;
  localparam logic [1:0] EV_FRAME = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic          stop_i;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_last_i;
  logic          s_ready_o;
  logic [AW-1:0] mem_waddr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_wen_o;
  logic          mem_sel_o;
  logic [AW-1:0] mem_raddr_o;
  logic [DW-1:0] mem_ts_i = '0;
  logic          trig_o;
  logic          frame_o;
  logic          busy_o;
  logic          shadow_ready_o;
  logic          err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int frame_cyc = 0;
  int frame_len = 0;
  int n_frames = 0;
  ev_t exp_q[$];

  logic [DW-1:0] bank0 [DEPTH];
  logic [DW-1:0] bank1 [DEPTH];

  always #5 clk = ~clk;

  timestamp_scheduler dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
`ifdef TS_TICK_EN
    .tick_i         (1'b1),
`endif
    .start_i        (start_i),
    .stop_i         (stop_i),
    .s_data_i       (s_data_i),
    .s_valid_i      (s_valid_i),
    .s_last_i       (s_last_i),
    .s_ready_o      (s_ready_o),
    .mem_waddr_o    (mem_waddr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wen_o      (mem_wen_o),
    .mem_sel_o      (mem_sel_o),
    .mem_raddr_o    (mem_raddr_o),
    .mem_ts_i       (mem_ts_i),
    .trig_o         (trig_o),
    .frame_o        (frame_o),
    .busy_o         (busy_o),
    .shadow_ready_o (shadow_ready_o),
    .err_o          (err_o)
  );

  // Two-bank memory: sel=1 writes bank1 / reads bank0; registered read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wen_o) begin
      if (mem_sel_o) bank1[mem_raddr_o == mem_raddr_o ? mem_waddr_o : '0] <= mem_wdata_o;
      else           bank0[mem_waddr_o] <= mem_wdata_o;
    end
    mem_ts_i <= mem_sel_o ? bank0[mem_raddr_o] : bank1[mem_raddr_o];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input string nm, input logic [1:0] kind, input logic [15:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event kind %0d value %0d, nothing expected (cycle %0d)",
               nm, kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      check(nm, {14'd0, kind, val}, {14'd0, e.kind, e.val});
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = 16'(val);
    exp_q.push_back(e);
  endtask

  // Monitor: every frame_o / trig_o / err_o is matched against the scoreboard
  initial begin
    int rel;
    forever begin
      @(negedge clk);
      if (rstn_i === 1'b1) begin
        if (frame_o) begin
          n_frames++;
          frame_len = cyc - frame_cyc;
          frame_cyc = cyc;
          pop_check("frame_sel", EV_FRAME, 16'(mem_sel_o));
        end
        rel = cyc - frame_cyc;
        if (trig_o) pop_check("trig_rel", EV_TRIG, 16'(rel));
        if (err_o)  pop_check("err", EV_ERR, 16'd1);
      end
    end
  end

  // Called at a negedge; the word is accepted at the following posedge
  task automatic push_word(input logic [DW-1:0] d, input logic last);
    int budget = 5000;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    while (!s_ready_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("load_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_data_i  = '0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int budget = 4000;
    while (n_frames < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("frame_timeout", 32'(n_frames), 32'(target));
  endtask

  task automatic wait_idle(input int limit);
    int budget = limit;
    while (busy_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("idle_reached", 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready_o), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_trig"}, 32'(trig_o), 32'd0);
    check({tag, "_frame"}, 32'(frame_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_sel"}, 32'(mem_sel_o), 32'd0);
    check({tag, "_shadow"}, 32'(shadow_ready_o), 32'd0);
    check({tag, "_wen"}, 32'(mem_wen_o), 32'd0);
    check({tag, "_raddr"}, 32'(mem_raddr_o), 32'd0);
    check({tag, "_waddr"}, 32'(mem_waddr_o), 32'd0);
  endtask

  initial begin
    int base;
    rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = '0;
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // start with no table: error pulse only
    push_ev(EV_ERR, 1);
    pulse_start();
    repeat (3) @(negedge clk);
    check("noload_busy", 32'(busy_o), 32'd0);
    check("noload_sel", 32'(mem_sel_o), 32'd0);
    check("noload_q", 32'(exp_q.size()), 32'd0);

    // table {5,10,20}: one frame, one replay, then stop
    push_word(16'd5, 1'b0);
    push_word(16'd10, 1'b0);
    push_word(16'd20, 1'b1);
    check("t1_shadow", 32'(shadow_ready_o), 32'd1);
    check("t1_s_ready", 32'(s_ready_o), 32'd0);
    for (int f = 0; f < 2; f++) begin
      push_ev(EV_FRAME, 1);
      push_ev(EV_TRIG, 5);
      push_ev(EV_TRIG, 10);
      push_ev(EV_TRIG, 20);
    end
    base = n_frames;
    pulse_start();
    wait_frames(base + 2);
    pulse_stop();
    wait_idle(200);
    check("t1_frame_len", 32'(frame_len), 32'd22);
    check("t1_q", 32'(exp_q.size()), 32'd0);
    check("t1_s_ready_back", 32'(s_ready_o), 32'd1);

    // table A {3,6} plays while table B {4} is loaded; B takes over at END
    push_word(16'd3, 1'b0);
    push_word(16'd6, 1'b1);
    push_ev(EV_FRAME, 0);
    push_ev(EV_TRIG, 3);
    push_ev(EV_TRIG, 6);
    push_ev(EV_FRAME, 1);
    push_ev(EV_TRIG, 4);
    base = n_frames;
    pulse_start();
    push_word(16'd4, 1'b1);
    check("t2_s_ready_drop", 32'(s_ready_o), 32'd0);
    check("t2_shadow", 32'(shadow_ready_o), 32'd1);
    wait_frames(base + 2);
    pulse_stop();
    wait_idle(200);
    check("t2_frame_len", 32'(frame_len), 32'd9);
    check("t2_s_ready_back", 32'(s_ready_o), 32'd1);
    check("t2_sel", 32'(mem_sel_o), 32'd1);
    check("t2_q", 32'(exp_q.size()), 32'd0);

    // table {0,0,1}: late entries fire on the first WAIT cycle
    push_word(16'd0, 1'b0);
    push_word(16'd0, 1'b0);
    push_word(16'd1, 1'b1);
    push_ev(EV_FRAME, 0);
    push_ev(EV_TRIG, 1);
    push_ev(EV_TRIG, 3);
    push_ev(EV_TRIG, 5);
    base = n_frames;
    pulse_start();
    wait_frames(base + 1);
    pulse_stop();
    wait_idle(200);
    check("t3_q", 32'(exp_q.size()), 32'd0);

    // full-depth table without s_last: entry i holds 2i+1
    for (int i = 0; i < int'(DEPTH); i++) push_word(16'(2 * i + 1), 1'b0);
    check("t4_shadow", 32'(shadow_ready_o), 32'd1);
    check("t4_s_ready", 32'(s_ready_o), 32'd0);
    check("t4_waddr_wrap", 32'(mem_waddr_o), 32'd0);
    push_ev(EV_FRAME, 1);
    for (int i = 0; i < int'(DEPTH); i++) push_ev(EV_TRIG, 2 * i + 1);
    base = n_frames;
    pulse_start();
    wait_frames(base + 1);
    pulse_stop();
    wait_idle(3000);
    check("t4_q", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a frame
    push_word(16'd7, 1'b1);
    push_ev(EV_FRAME, 0);
    base = n_frames;
    pulse_start();
    wait_frames(base + 1);
    rstn_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rstn_i = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_q", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
